// File: rtl/skew_pipe.sv
// Stallable per-lane skew/deskew delay line feeding a systolic array edge; lane i lags by d_i advances plus one output register.
// Upstream handshake only (in_ready drops while draining); out_valid is a pulse the consumer must take.
module skew_pipe #(
   parameter int LANES = 4,
   parameter int WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [LANES*WIDTH-1:0]   in_data,
   input  logic                     mode,
   input  logic                     flush,
   output logic [LANES-1:0]         out_valid,
   output logic [LANES*WIDTH-1:0]   out_data,
   output logic                     busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // At least one stage is allocated so LANES=1 still elaborates; unused stages stay zero.
   localparam int SD = (LANES > 1) ? LANES - 1 : 1;

   state_t                               state_q, state_d;
   logic                                 mode_q, mode_eff, accept, advance;
   logic [LANES-1:0][SD-1:0]             sv_q, sv_d;
   logic [LANES-1:0][SD-1:0][WIDTH-1:0]  sd_q, sd_d;
   logic [LANES-1:0]                     sel_v;
   logic [LANES-1:0][WIDTH-1:0]          sel_d;

   assign in_ready = (state_q != DRAIN);
   assign accept   = in_valid && in_ready;
   assign advance  = accept || (state_q == DRAIN);
   // The accept that leaves IDLE already runs with the mode being latched.
   assign mode_eff = (state_q == IDLE) ? mode : mode_q;
   assign busy     = (|sv_q) || (state_q != IDLE);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int DS = i;
      localparam int DD = LANES - 1 - i;

      logic             src_v, tap_sv, tap_dv;
      logic [WIDTH-1:0] src_d, tap_sd, tap_dd;

      assign src_v = accept;
      assign src_d = accept ? in_data[i*WIDTH +: WIDTH] : '0;

      if (DS == 0) begin : g_s0
         assign tap_sv = src_v;
         assign tap_sd = src_d;
      end else begin : g_sn
         assign tap_sv = sv_q[i][DS-1];
         assign tap_sd = sd_q[i][DS-1];
      end

      if (DD == 0) begin : g_d0
         assign tap_dv = src_v;
         assign tap_dd = src_d;
      end else begin : g_dn
         assign tap_dv = sv_q[i][DD-1];
         assign tap_dd = sd_q[i][DD-1];
      end

      assign sel_v[i] = mode_eff ? tap_dv : tap_sv;
      assign sel_d[i] = mode_eff ? tap_dd : tap_sd;

      for (genvar k = 0; k < SD; k++) begin : g_stage
         localparam bit IN_S = (k < DS);
         localparam bit IN_D = (k < DD);

         logic             in_rng, prev_v;
         logic [WIDTH-1:0] prev_d;

         if (k == 0) begin : g_first
            assign prev_v = src_v;
            assign prev_d = src_d;
         end else begin : g_next
            assign prev_v = sv_q[i][k-1];
            assign prev_d = sd_q[i][k-1];
         end

         // Stages beyond this lane's depth are forced empty so busy/drain see only live data.
         assign in_rng      = mode_eff ? IN_D : IN_S;
         assign sv_d[i][k]  = !advance ? sv_q[i][k] : (in_rng && prev_v);
         assign sd_d[i][k]  = !advance ? sd_q[i][k] : (in_rng ? prev_d : '0);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (!(|sv_d)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= 1'b0;
         sv_q      <= '0;
         sd_q      <= '0;
         out_valid <= '0;
         out_data  <= '0;
      end else begin
         state_q   <= state_d;
         sv_q      <= sv_d;
         sd_q      <= sd_d;
         if (state_q == IDLE && accept) mode_q <= mode;
         out_valid <= advance ? sel_v : '0;
         if (advance) out_data <= sel_d;
      end
   end

endmodule

// File: tb/tb_skew_pipe.sv
// Bench for skew_pipe: directed scenarios plus randomized traffic against a per-advance history model.
module tb_skew_pipe;

   localparam int L = 4;
   localparam int W = 5;
   typedef logic [L*W-1:0] vec_t;
   typedef struct packed {logic v; vec_t d;} ent_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0, mode = 1'b0, flush = 1'b0;
   vec_t         in_data = '0;
   logic         in_ready, busy;
   logic [L-1:0] out_valid;
   vec_t         out_data;

   logic         in_valid1 = 1'b0, mode1 = 1'b0, flush1 = 1'b0;
   logic [3:0]   in_data1 = '0;
   logic         in_ready1, busy1;
   logic [0:0]   out_valid1;
   logic [3:0]   out_data1;

   int checks = 0;
   int errors = 0;

   // Reference model: the stream of advances, each carrying an element or a bubble.
   ent_t         hist[$];
   int           m_state;
   logic         m_mode;
   logic [L-1:0] exp_ov;
   vec_t         exp_od;
   logic         exp_busy, exp_rdy, rdy_obs;

   always #5 clk = ~clk;

   skew_pipe #(.LANES(L), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .mode(mode), .flush(flush),
      .out_valid(out_valid), .out_data(out_data), .busy(busy)
   );

   skew_pipe #(.LANES(1), .WIDTH(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1), .mode(mode1), .flush(flush1),
      .out_valid(out_valid1), .out_data(out_data1), .busy(busy1)
   );

   function automatic vec_t mkvec(input int k);
      vec_t v;
      for (int i = 0; i < L; i++) v[i*W +: W] = W'(4*k + i + 1);
      return v;
   endfunction

   task automatic model_reset();
      hist.delete();
      m_state  = 0;
      m_mode   = 1'b0;
      exp_ov   = '0;
      exp_od   = '0;
      exp_busy = 1'b0;
      exp_rdy  = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; mode = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // One clock: drive inputs, sample in_ready, clock, and advance the model.
   task automatic cyc(input logic v, input vec_t d, input logic md, input logic fl);
      logic acc, adv, me, ne;
      int   di, idx;
      ent_t e;
      @(negedge clk);
      in_valid = v; in_data = d; mode = md; flush = fl;
      #1 rdy_obs = in_ready;
      exp_rdy = (m_state != 2);
      acc = v && exp_rdy;
      adv = acc || (m_state == 2);
      me  = (m_state == 0) ? md : m_mode;
      if (adv) begin
         e.v = acc;
         e.d = acc ? d : '0;
         hist.push_back(e);
         for (int i = 0; i < L; i++) begin
            di  = me ? (L - 1 - i) : i;
            idx = hist.size() - 1 - di;
            if (idx >= 0) begin
               exp_ov[i]         = hist[idx].v;
               exp_od[i*W +: W]  = hist[idx].d[i*W +: W];
            end else begin
               exp_ov[i]         = 1'b0;
               exp_od[i*W +: W]  = '0;
            end
         end
      end else begin
         exp_ov = '0;
      end
      ne = 1'b0;
      for (int i = 0; i < L; i++) begin
         di = me ? (L - 1 - i) : i;
         for (int j = 0; j < di; j++) begin
            idx = hist.size() - 1 - j;
            if (idx >= 0 && hist[idx].v) ne = 1'b1;
         end
      end
      case (m_state)
         0: if (acc) begin m_state = 1; m_mode = md; end
         1: if (fl) m_state = 2;
         default: if (!ne) begin m_state = 0; hist.delete(); end
      endcase
      exp_busy = ne || (m_state != 0);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_ov: got %b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_od: got %h want 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b want 1", in_ready); end
      checks++; if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b1) begin
         errors++; $display("FAIL reset_l1: ov=%b busy=%b rdy=%b want 0 0 1", out_valid1, busy1, in_ready1);
      end
   endtask

   task automatic test_skew();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, mkvec(k), 1'b0, k == 3);
         checks++;
         if (out_valid[0] !== 1'b1 || out_data[0 +: W] !== W'(4*k + 1)) begin
            errors++; $display("FAIL skew_lane0 A%0d: got v=%b d=%0d want v=1 d=%0d", k, out_valid[0], out_data[0 +: W], 4*k + 1);
         end
      end
      checks++;
      if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== W'(4)) begin
         errors++; $display("FAIL skew_lane3 A3: got v=%b d=%0d want v=1 d=4", out_valid[3], out_data[3*W +: W]);
      end
      for (int j = 1; j <= 3; j++) begin
         cyc(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (rdy_obs !== 1'b0) begin errors++; $display("FAIL skew_rdy D%0d: got %b want 0", j, rdy_obs); end
         checks++;
         if (out_valid[3] !== 1'b1 || out_data[3*W +: W] !== W'(4*j + 4)) begin
            errors++; $display("FAIL skew_lane3 D%0d: got v=%b d=%0d want v=1 d=%0d", j, out_valid[3], out_data[3*W +: W], 4*j + 4);
         end
      end
      checks++; if (out_valid[2] !== 1'b0) begin errors++; $display("FAIL skew_lane2 D3: got v=%b want 0", out_valid[2]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skew_busy_end: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skew_idle_rdy: got %b want 1", in_ready); end
   endtask

   task automatic test_stall();
      vec_t held;
      do_reset();
      for (int c = 0; c < 15; c++) begin
         if (c < 2 || (c >= 7 && c < 9)) cyc(1'b1, vec_t'($urandom), 1'b0, c == 8);
         else cyc(1'b0, '0, 1'b0, 1'b0);
         if (c == 1) held = exp_od;
         if (c >= 2 && c < 7) begin
            checks++;
            if (out_valid !== '0 || out_data !== held) begin
               errors++; $display("FAIL stall_hold c%0d: got v=%b d=%h want v=0 d=%h", c, out_valid, out_data, held);
            end
         end
         checks++; if (rdy_obs !== exp_rdy) begin errors++; $display("FAIL stall_rdy c%0d: got %b want %b", c, rdy_obs, exp_rdy); end
         checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL stall_ov c%0d: got %b want %b", c, out_valid, exp_ov); end
         checks++; if (out_data !== exp_od) begin errors++; $display("FAIL stall_od c%0d: got %h want %h", c, out_data, exp_od); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL stall_busy c%0d: got %b want %b", c, busy, exp_busy); end
      end
   endtask

   task automatic test_deskew();
      do_reset();
      cyc(1'b1, mkvec(0), 1'b1, 1'b0);
      checks++;
      if (out_valid !== 4'b1000 || out_data[3*W +: W] !== W'(4)) begin
         errors++; $display("FAIL deskew_lane3: got v=%b d=%0d want v=1000 d=4", out_valid, out_data[3*W +: W]);
      end
      cyc(1'b0, '0, 1'b1, 1'b1);
      checks++; if (out_valid !== '0) begin errors++; $display("FAIL deskew_flushcyc: got %b want 0", out_valid); end
      for (int j = 1; j <= 3; j++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (out_valid !== (4'b1000 >> j) || out_data[(3-j)*W +: W] !== W'(4 - j)) begin
            errors++; $display("FAIL deskew_D%0d: got v=%b d=%0d want v=%b d=%0d", j, out_valid, out_data[(3-j)*W +: W], 4'b1000 >> j, 4 - j);
         end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL deskew_busy: got %b want 0", busy); end
   endtask

   task automatic test_mode_toggle();
      do_reset();
      for (int c = 0; c < 19; c++) begin
         if (c < 7) cyc(1'b1, vec_t'($urandom), c[0], c == 6);
         else if (c < 11) cyc(1'b0, '0, c[0], 1'b0);
         else if (c < 14) cyc(1'b1, vec_t'($urandom), 1'b1, c == 13);
         else cyc(1'b0, '0, c[0], 1'b0);
         if (c < 7) begin
            checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL toggle_lane0 c%0d: got %b want 1", c, out_valid[0]); end
         end
         if (c == 11) begin
            checks++; if (out_valid !== 4'b1000) begin errors++; $display("FAIL toggle_newmode: got %b want 1000", out_valid); end
         end
         checks++; if (rdy_obs !== exp_rdy) begin errors++; $display("FAIL toggle_rdy c%0d: got %b want %b", c, rdy_obs, exp_rdy); end
         checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL toggle_ov c%0d: got %b want %b", c, out_valid, exp_ov); end
         checks++; if (out_data !== exp_od) begin errors++; $display("FAIL toggle_od c%0d: got %h want %h", c, out_data, exp_od); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL toggle_busy c%0d: got %b want %b", c, busy, exp_busy); end
      end
   endtask

   task automatic test_accept_flush();
      do_reset();
      for (int c = 0; c < 6; c++) begin
         if (c < 2) cyc(1'b1, vec_t'($urandom), 1'b0, c == 1);
         else cyc(1'b0, '0, 1'b0, 1'b0);
         checks++; if (rdy_obs !== exp_rdy) begin errors++; $display("FAIL af_rdy c%0d: got %b want %b", c, rdy_obs, exp_rdy); end
         checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL af_ov c%0d: got %b want %b", c, out_valid, exp_ov); end
         checks++; if (out_data !== exp_od) begin errors++; $display("FAIL af_od c%0d: got %h want %h", c, out_data, exp_od); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL af_busy c%0d: got %b want %b", c, busy, exp_busy); end
      end
      cyc(1'b1, vec_t'($urandom), 1'b0, 1'b0);
      cyc(1'b1, vec_t'($urandom), 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== '0 || out_data !== '0) begin errors++; $display("FAIL drain_reset_out: got v=%b d=%h want 0 0", out_valid, out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_reset_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_reset_rdy: got %b want 1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_lanes1();
      @(negedge clk);
      in_valid1 = 1'b1; in_data1 = 4'hA;
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== 4'hA) begin errors++; $display("FAIL l1_out: got v=%b d=%h want 1 a", out_valid1, out_data1); end
      @(negedge clk);
      in_valid1 = 1'b0; flush1 = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL l1_drain_rdy: got %b want 0", in_ready1); end
      @(negedge clk);
      flush1 = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL l1_bubble: got %b want 0", out_valid1); end
      checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL l1_idle: rdy=%b busy=%b want 1 0", in_ready1, busy1); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if (c < 394) cyc($urandom_range(0, 9) < 7, vec_t'($urandom), 1'($urandom), $urandom_range(0, 9) == 0);
         else cyc(1'b0, '0, 1'b0, c == 394);
         checks++; if (rdy_obs !== exp_rdy) begin errors++; $display("FAIL rand_rdy c%0d: got %b want %b", c, rdy_obs, exp_rdy); end
         checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rand_ov c%0d: got %b want %b", c, out_valid, exp_ov); end
         checks++; if (out_data !== exp_od) begin errors++; $display("FAIL rand_od c%0d: got %h want %h", c, out_data, exp_od); end
         checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, exp_busy); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_skew();
      test_stall();
      test_deskew();
      test_mode_toggle();
      test_accept_flush();
      test_lanes1();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
